// File: rtl/tpm_spi_pkg.sv
// Shared constants for the TPM SPI front end: TX request FSM encoding,
// the SPI mode served by the PHY, and the idle MISO byte.
package tpm_spi_pkg;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_REQ    = 2'd1;
    localparam logic [1:0] T_LOADED = 2'd2;

    // {CPOL, CPHA}: sample MOSI on SCLK rise, change MISO on SCLK fall.
    localparam logic [1:0] SPI_MODE = 2'b00;

    localparam logic [7:0] DEFAULT_TX_BYTE = 8'h00;

endpackage

// File: rtl/tpm_spi_sync.sv
// Multi-flop synchroniser for one raw SPI pin; the reset value matches the
// pin's idle level so reset never produces a spurious edge.
module tpm_spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/tpm_spi_phy.sv
// Byte-level SPI mode-0 slave PHY: oversamples the pins in the system clock
// domain, assembles RX bytes and serialises controller-supplied TX bytes.
module tpm_spi_phy
    import tpm_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEFAULT_TX  = DEFAULT_TX_BYTE
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pin_SCLK,
    input  logic       pin_CS_n,
    input  logic       pin_MOSI,
    output logic       pin_MISO,
    output logic       pin_MISO_oe,
    output logic       SPI_CS_n,
    output logic [7:0] SPI_RX_byte,
    output logic       SPI_RX_valid,
    output logic       SPI_TX_prepare,
    input  logic [7:0] SPI_TX_byte,
    input  logic       SPI_TX_valid,
    output logic       SPI_TX_ack
);

    logic       w_sclk_s;
    logic       w_cs_s;
    logic       w_mosi_s;
    logic       w_rise;
    logic       w_fall;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_sel;
    logic       w_boundary;

    logic       r_sclk_d;
    logic       r_cs_d;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_rx_byte;
    logic       r_rx_valid;
    logic [7:0] r_tx_shift;
    logic [7:0] r_tx_buf;
    logic       r_tx_buf_full;
    logic [1:0] r_tx_state;
    logic       r_tx_prepare;
    logic       r_tx_ack;

    tpm_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clock(clock), .reset_n(reset_n), .i_d(pin_SCLK), .o_q(w_sclk_s)
    );
    tpm_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clock(clock), .reset_n(reset_n), .i_d(pin_CS_n), .o_q(w_cs_s)
    );
    tpm_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clock(clock), .reset_n(reset_n), .i_d(pin_MOSI), .o_q(w_mosi_s)
    );

    assign w_rise     = w_sclk_s & ~r_sclk_d;
    assign w_fall     = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall  = ~w_cs_s & r_cs_d;
    assign w_cs_rise  = w_cs_s & ~r_cs_d;
    assign w_sel      = ~w_cs_s;
    // The fall after the eighth rise is where the next slot's byte is loaded.
    assign w_boundary = w_sel & w_fall & (r_bit_cnt == 3'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_d      <= 1'b0;
            r_cs_d        <= 1'b1;
            r_bit_cnt     <= 3'd0;
            r_rx_shift    <= 8'h00;
            r_rx_byte     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_tx_shift    <= 8'hFF;
            r_tx_buf      <= 8'h00;
            r_tx_buf_full <= 1'b0;
            r_tx_state    <= T_IDLE;
            r_tx_prepare  <= 1'b0;
            r_tx_ack      <= 1'b0;
        end else begin
            r_sclk_d     <= w_sclk_s;
            r_cs_d       <= w_cs_s;
            r_rx_valid   <= 1'b0;
            r_tx_prepare <= 1'b0;
            r_tx_ack     <= 1'b0;

            if (w_cs_fall) begin
                r_bit_cnt     <= 3'd0;
                r_tx_shift    <= DEFAULT_TX;
                r_tx_buf_full <= 1'b0;
                r_tx_state    <= T_IDLE;
            end else if (w_cs_rise) begin
                // Abort: any partial RX byte is dropped, pending TX byte discarded.
                r_bit_cnt     <= 3'd0;
                r_tx_buf_full <= 1'b0;
                r_tx_state    <= T_IDLE;
            end else if (w_sel) begin
                if (w_rise) begin
                    r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_rx_byte  <= {r_rx_shift[6:0], w_mosi_s};
                        r_rx_valid <= 1'b1;
                    end
                end else if (w_fall) begin
                    if (r_bit_cnt != 3'd0) begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end else begin
                        r_tx_shift    <= r_tx_buf_full ? r_tx_buf : DEFAULT_TX;
                        r_tx_buf_full <= 1'b0;
                    end
                end

                // A boundary always wins over a same-cycle capture so a byte is
                // never loaded into a slot that has already started.
                if (w_boundary) begin
                    r_tx_state <= T_IDLE;
                end else if (w_rise && r_bit_cnt == 3'd0 && r_tx_state == T_IDLE) begin
                    r_tx_state   <= T_REQ;
                    r_tx_prepare <= 1'b1;
                end else if (r_tx_state == T_REQ && SPI_TX_valid) begin
                    r_tx_buf      <= SPI_TX_byte;
                    r_tx_buf_full <= 1'b1;
                    r_tx_ack      <= 1'b1;
                    r_tx_state    <= T_LOADED;
                end
            end
        end
    end

    assign SPI_CS_n       = r_cs_d;
    assign pin_MISO_oe    = ~r_cs_d;
    assign pin_MISO       = r_tx_shift[7];
    assign SPI_RX_byte    = r_rx_byte;
    assign SPI_RX_valid   = r_rx_valid;
    assign SPI_TX_prepare = r_tx_prepare;
    assign SPI_TX_ack     = r_tx_ack;

endmodule

// File: tb/tb_tpm_spi_phy.sv
// Directed bench for tpm_spi_phy: SPI master and controller drivers, RX/MISO
// scoreboards with expected queues, and handshake counters from a monitor.
module tb_tpm_spi_phy;

    logic       clock;
    logic       reset_n;
    logic       pin_SCLK;
    logic       pin_CS_n;
    logic       pin_MOSI;
    logic       pin_MISO;
    logic       pin_MISO_oe;
    logic       SPI_CS_n;
    logic [7:0] SPI_RX_byte;
    logic       SPI_RX_valid;
    logic       SPI_TX_prepare;
    logic [7:0] SPI_TX_byte;
    logic       SPI_TX_valid;
    logic       SPI_TX_ack;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] rx_got_q[$];
    logic [7:0] tx_exp_q[$];

    int cyc = 0;
    int prep_cnt = 0;
    int ack_cnt = 0;
    int prep_cyc = 0;
    int ack_cyc = 0;
    int rx_wide = 0;
    logic rx_prev = 1'b0;

    tpm_spi_phy #(.SYNC_STAGES(2), .DEFAULT_TX(8'h00)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .pin_SCLK(pin_SCLK),
        .pin_CS_n(pin_CS_n),
        .pin_MOSI(pin_MOSI),
        .pin_MISO(pin_MISO),
        .pin_MISO_oe(pin_MISO_oe),
        .SPI_CS_n(SPI_CS_n),
        .SPI_RX_byte(SPI_RX_byte),
        .SPI_RX_valid(SPI_RX_valid),
        .SPI_TX_prepare(SPI_TX_prepare),
        .SPI_TX_byte(SPI_TX_byte),
        .SPI_TX_valid(SPI_TX_valid),
        .SPI_TX_ack(SPI_TX_ack)
    );

    // ---------------- clock / watchdog ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got running exp finished");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        cyc <= cyc + 1;
        rx_prev <= SPI_RX_valid;
        if (SPI_TX_prepare) begin
            prep_cnt <= prep_cnt + 1;
            prep_cyc <= cyc;
        end
        if (SPI_TX_ack) begin
            ack_cnt <= ack_cnt + 1;
            ack_cyc <= cyc;
        end
        if (SPI_RX_valid) rx_got_q.push_back(SPI_RX_byte);
        if (SPI_RX_valid && rx_prev) rx_wide <= rx_wide + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] e;
        logic [7:0] g;
        while (rx_exp_q.size() > 0) begin
            e = rx_exp_q.pop_front();
            if (rx_got_q.size() > 0) g = rx_got_q.pop_front();
            else g = 8'hxx;
            check(tag, {24'h0, g}, {24'h0, e});
        end
        check({tag, "_extra"}, rx_got_q.size(), 0);
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Each SCLK half period is 4 system clocks (SCLK = clock/8).
    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            pin_MOSI = mo[i];
            tick(4);
            mi[i] = pin_MISO;
            pin_SCLK = 1'b1;
            tick(4);
            pin_SCLK = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] mo, input logic [7:0] miso_exp);
        logic [7:0] mi;
        logic [7:0] e;
        rx_exp_q.push_back(mo);
        tx_exp_q.push_back(miso_exp);
        spi_bits(mo, 8, mi);
        e = tx_exp_q.pop_front();
        check("miso_byte", {24'h0, mi}, {24'h0, e});
    endtask

    task automatic cs_low();
        pin_CS_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_high();
        tick(4);
        pin_CS_n = 1'b1;
        tick(8);
    endtask

    task automatic ctrl_serve(input logic [7:0] b, input int dly, input int hold);
        int n;
        n = 0;
        while (!SPI_TX_prepare && n < 600) begin
            @(negedge clock);
            n++;
        end
        check("ctrl_prep_seen", SPI_TX_prepare, 1);
        tick(dly);
        SPI_TX_byte  = b;
        SPI_TX_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!SPI_TX_ack && n < 20);
        check("ctrl_ack_within_20", SPI_TX_ack, 1);
        tick(hold);
        SPI_TX_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int p0;
        int a0;
        int d;
        int n;
        logic [7:0] junk;

        reset_n      = 1'b0;
        pin_SCLK     = 1'b0;
        pin_CS_n     = 1'b1;
        pin_MOSI     = 1'b0;
        SPI_TX_byte  = 8'h00;
        SPI_TX_valid = 1'b0;
        tick(5);

        check("rst_cs_n", SPI_CS_n, 1);
        check("rst_rx_byte", SPI_RX_byte, 8'h00);
        check("rst_rx_valid", SPI_RX_valid, 0);
        check("rst_prepare", SPI_TX_prepare, 0);
        check("rst_ack", SPI_TX_ack, 0);
        check("rst_miso", pin_MISO, 1);
        check("rst_miso_oe", pin_MISO_oe, 0);
        reset_n = 1'b1;
        tick(5);

        // RX: four bytes, MISO idle bytes, one prepare per byte, no acks
        p0 = prep_cnt; a0 = ack_cnt;
        cs_low();
        check("cs_sync_low", SPI_CS_n, 0);
        check("oe_selected", pin_MISO_oe, 1);
        send(8'h83, 8'h00);
        send(8'hD4, 8'h00);
        send(8'h00, 8'h00);
        send(8'h24, 8'h00);
        cs_high();
        check_rx("rx_seq");
        check("rx_pulse_width", rx_wide, 0);
        check("rx_prepares", prep_cnt - p0, 4);
        check("rx_no_ack", ack_cnt - a0, 0);
        check("rx_byte_hold", SPI_RX_byte, 8'h24);

        // TX on time: controller answers within a few cycles
        p0 = prep_cnt; a0 = ack_cnt;
        cs_low();
        fork
            begin
                send(8'h11, 8'h00);
                send(8'h22, 8'hA5);
                send(8'h33, 8'h3C);
            end
            begin
                ctrl_serve(8'hA5, 3, 0);
                ctrl_serve(8'h3C, 3, 0);
            end
        join
        cs_high();
        check_rx("tx_ontime_rx");
        check("ontime_prepares", prep_cnt - p0, 3);
        check("ontime_acks", ack_cnt - a0, 2);

        // TX late: valid appears only after byte 1 has been loaded
        a0 = ack_cnt;
        d = -1;
        cs_low();
        send(8'h10, 8'h00);
        tick(6);
        SPI_TX_byte  = 8'hA5;
        SPI_TX_valid = 1'b1;
        fork
            begin
                send(8'h20, 8'h00);
                send(8'h30, 8'hA5);
            end
            begin
                n = 0;
                do begin
                    @(negedge clock);
                    #1;
                    n++;
                end while (!SPI_TX_ack && n < 300);
                d = ack_cyc - prep_cyc;
                SPI_TX_valid = 1'b0;
            end
        join
        cs_high();
        check_rx("tx_late_rx");
        check("late_acks", ack_cnt - a0, 1);
        check("late_ack_after_prepare", d, 1);

        // Held valid: valid stays high 3 cycles past the ack
        p0 = prep_cnt; a0 = ack_cnt;
        cs_low();
        fork
            begin
                send(8'h5C, 8'h00);
                send(8'hE1, 8'h77);
                send(8'h0B, 8'h00);
            end
            ctrl_serve(8'h77, 2, 3);
        join
        cs_high();
        check_rx("held_rx");
        check("held_prepares", prep_cnt - p0, 3);
        check("held_single_ack", ack_cnt - a0, 1);

        // CS abort after 5 bits of FF
        cs_low();
        spi_bits(8'hFF, 5, junk);
        pin_CS_n = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        check("abort_cs_not_yet", SPI_CS_n, 0);
        @(posedge clock); #1;
        check("abort_cs_synced", SPI_CS_n, 1);
        check("abort_oe_off", pin_MISO_oe, 0);
        tick(8);
        check_rx("abort_no_rx");
        check("abort_rx_byte_kept", SPI_RX_byte, 8'h0B);
        cs_low();
        check("abort_next_miso_start", pin_MISO, 0);
        send(8'h5A, 8'h00);
        cs_high();
        check_rx("after_abort_rx");

        // Asynchronous reset in the middle of a byte
        cs_low();
        spi_bits(8'h0F, 3, junk);
        check("pre_reset_oe", pin_MISO_oe, 1);
        reset_n = 1'b0;
        #1;
        check("arst_cs_n", SPI_CS_n, 1);
        check("arst_rx_byte", SPI_RX_byte, 8'h00);
        check("arst_rx_valid", SPI_RX_valid, 0);
        check("arst_prepare", SPI_TX_prepare, 0);
        check("arst_ack", SPI_TX_ack, 0);
        check("arst_miso", pin_MISO, 1);
        check("arst_miso_oe", pin_MISO_oe, 0);
        pin_CS_n = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
